// File: rtl/core2uart_master_pkg.sv
// Shared constants and types for the core-to-UART bridge master.
// Holds the FSM encoding, op codes and the fixed frame bytes.
package core2uart_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitRd,
        StWaitAck,
        StDone
    } state_e;

    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;

    localparam logic [7:0] PrefixByte     = 8'h00;
    localparam logic [7:0] LengthByte     = 8'h01;
    localparam logic [7:0] DefaultAckByte = 8'h5A;

    function automatic logic [7:0] cmd_byte(input logic [1:0] op);
        return {2'b00, op, 4'b0001};
    endfunction

endpackage

// File: rtl/core2uart_master.sv
// Core-side request port that serialises single-byte register accesses into a
// UART frame and collects the read data / acknowledge reply.
module core2uart_master
    import core2uart_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ACK_BYTE       = DefaultAckByte
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data
);

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        new_tx_data_q, new_tx_data_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;

    logic [7:0]  frame_byte;
    logic [2:0]  last_idx;
    logic        timed_out;

    // Writes carry one extra byte (wdata) after the address.
    assign last_idx  = write_q ? 3'd5 : 3'd4;
    assign timed_out = (timer_q == TimeoutLast);

    always_comb begin
        frame_byte = wdata_q;
        unique case (byte_idx_q)
            3'd0:    frame_byte = PrefixByte;
            3'd1:    frame_byte = cmd_byte(write_q ? OpWrite : OpRead);
            3'd2:    frame_byte = LengthByte;
            3'd3:    frame_byte = addr_q[15:8];
            3'd4:    frame_byte = addr_q[7:0];
            default: frame_byte = wdata_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        byte_idx_d    = byte_idx_q;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;
        timer_d       = timer_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    byte_idx_d  = 3'd0;
                    rsp_rdata_d = 8'h00;
                    rsp_error_d = 1'b0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                // Strobes are never back-to-back so the UART has a cycle to raise busy.
                if (!tx_busy && !new_tx_data_q) begin
                    tx_data_d     = frame_byte;
                    new_tx_data_d = 1'b1;
                    byte_idx_d    = byte_idx_q + 3'd1;
                    if (byte_idx_q == last_idx) begin
                        timer_d = '0;
                        state_d = write_q ? StWaitAck : StWaitRd;
                    end
                end
            end
            StWaitRd: begin
                if (new_rx_data) begin
                    rsp_rdata_d = rx_data;
                    timer_d     = '0;
                    state_d     = StWaitAck;
                end else if (timed_out) begin
                    rsp_error_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StWaitAck: begin
                if (new_rx_data) begin
                    if (rx_data != ACK_BYTE) begin
                        rsp_error_d = 1'b1;
                    end
                    timer_d = '0;
                    state_d = StDone;
                end else if (timed_out) begin
                    rsp_error_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            write_q       <= 1'b0;
            addr_q        <= 16'h0000;
            wdata_q       <= 8'h00;
            byte_idx_q    <= 3'd0;
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
            timer_q       <= '0;
            rsp_rdata_q   <= 8'h00;
            rsp_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            byte_idx_q    <= byte_idx_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
            timer_q       <= timer_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StDone);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;

endmodule

// File: tb/tb_core2uart_master.sv
// Scoreboard bench for core2uart_master: expected tx bytes and responses are
// queued by the stimulus and consumed by a negedge monitor with a UART model.
module tb_core2uart_master;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       chk_lat;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        new_rx_data = 1'b0;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   strobes_seen = 0;
    int   hold_strobe_no = -1;
    int   busy_cnt = 0;
    int   last_strobe_cyc = 0;
    logic prev_ntx = 1'b0;

    logic [7:0] exp_tx[$];
    rsp_t       exp_rsp[$];

    core2uart_master #(
        .TIMEOUT_CYCLES(50),
        .ACK_BYTE(8'h5A)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .tx_data(tx_data),
        .new_tx_data(new_tx_data),
        .tx_busy(tx_busy),
        .rx_data(rx_data),
        .new_rx_data(new_rx_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // UART transmitter model plus tx/rsp scoreboard monitor.
    always @(negedge clock) begin
        cyc++;
        if (new_tx_data) begin
            chk("strobe_gap", {30'd0, tx_busy, prev_ntx}, 32'd0);
            if (exp_tx.size() == 0) begin
                chk("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
            strobes_seen++;
            last_strobe_cyc = cyc;
            busy_cnt = (strobes_seen == hold_strobe_no) ? 200 : 10;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = (busy_cnt > 0);
        prev_ntx = new_tx_data;
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp", {23'd0, rsp_rdata, rsp_error}, 32'hFFFF_FFFF);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
                chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
                if (e.chk_lat) chk("timeout_latency", cyc - last_strobe_cyc, 32'd50);
            end
        end
    end

    task automatic push_frame(input logic wr, input logic [15:0] a, input logic [7:0] d);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(wr ? 8'h21 : 8'h11);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(a[15:8]);
        exp_tx.push_back(a[7:0]);
        if (wr) exp_tx.push_back(d);
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) chk("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clock);
        chk("ready_drop", {31'd0, req_ready}, 32'd0);
        // Held-valid garbage must be ignored while busy.
        req_write = ~wr;
        req_addr  = 16'hDEAD;
        req_wdata = 8'hBE;
        repeat (2) @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clock);
        rx_data = b;
        new_rx_data = 1'b1;
        @(negedge clock);
        new_rx_data = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int n;
        n = 0;
        while (exp_tx.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) chk("frame_timeout", exp_tx.size(), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_rsp(input int budget);
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) chk("rsp_timeout", exp_rsp.size(), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("reset_error", {31'd0, rsp_error}, 32'd0);
        chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
        chk("reset_new_tx", {31'd0, new_tx_data}, 32'd0);
        reset = 1'b0;
        send_rx(8'h77);

        // Write with good ack.
        push_frame(1'b1, 16'h1234, 8'hA5);
        exp_rsp.push_back('{rdata: 8'h00, err: 1'b0, chk_lat: 1'b0});
        issue(1'b1, 16'h1234, 8'hA5);
        wait_frame(2000);
        send_rx(8'h5A);
        wait_rsp(200);

        // Read with a stray rx byte during SEND.
        push_frame(1'b0, 16'h00FF, 8'h00);
        exp_rsp.push_back('{rdata: 8'h3C, err: 1'b0, chk_lat: 1'b0});
        issue(1'b0, 16'h00FF, 8'h00);
        send_rx(8'hEE);
        wait_frame(2000);
        send_rx(8'h3C);
        repeat (3) @(negedge clock);
        send_rx(8'h5A);
        wait_rsp(200);
        repeat (5) @(negedge clock);
        chk("rdata_held", {24'd0, rsp_rdata}, 32'h3C);

        // Write with bad ack.
        push_frame(1'b1, 16'h0042, 8'h7E);
        exp_rsp.push_back('{rdata: 8'h00, err: 1'b1, chk_lat: 1'b0});
        issue(1'b1, 16'h0042, 8'h7E);
        wait_frame(2000);
        send_rx(8'h00);
        wait_rsp(200);

        // Read timeout, no reply.
        push_frame(1'b0, 16'hBEEF, 8'h00);
        exp_rsp.push_back('{rdata: 8'h00, err: 1'b1, chk_lat: 1'b1});
        issue(1'b0, 16'hBEEF, 8'h00);
        wait_frame(2000);
        wait_rsp(200);

        // Long busy after the third byte.
        hold_strobe_no = strobes_seen + 3;
        push_frame(1'b1, 16'hA55A, 8'h3C);
        exp_rsp.push_back('{rdata: 8'h00, err: 1'b0, chk_lat: 1'b0});
        issue(1'b1, 16'hA55A, 8'h3C);
        wait_frame(3000);
        send_rx(8'h5A);
        wait_rsp(200);
        hold_strobe_no = -1;

        // Reset after the second byte aborts the write.
        begin
            int base;
            int n;
            base = strobes_seen;
            exp_tx.push_back(8'h00);
            exp_tx.push_back(8'h21);
            issue(1'b1, 16'h5555, 8'h66);
            n = 0;
            while (strobes_seen < base + 2 && n < 1000) begin
                @(negedge clock);
                n++;
            end
            if (n >= 1000) chk("abort_wait", strobes_seen - base, 32'd2);
            reset = 1'b1;
            repeat (2) @(negedge clock);
            chk("abort_ready", {31'd0, req_ready}, 32'd1);
            chk("abort_new_tx", {31'd0, new_tx_data}, 32'd0);
            reset = 1'b0;
            repeat (30) @(negedge clock);
            chk("abort_bytes", strobes_seen - base, 32'd2);
        end
        push_frame(1'b0, 16'h0102, 8'h00);
        exp_rsp.push_back('{rdata: 8'h99, err: 1'b0, chk_lat: 1'b0});
        issue(1'b0, 16'h0102, 8'h00);
        wait_frame(2000);
        send_rx(8'h99);
        send_rx(8'h5A);
        wait_rsp(200);
        chk("tx_queue_empty", exp_tx.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
